// File: rtl/tcb_riscv_test_ctl_if.sv
// rtl/tcb_riscv_test_ctl_if.sv - load/store TCB bus interface for the test controller
interface tcb_riscv_test_ctl_if #(
  parameter int DAW = 22,
  parameter int DDW = 32,
  parameter int DBW = DDW/8
);
  logic           vld;
  logic           wen;
  logic [DAW-1:0] adr;
  logic [DBW-1:0] ben;
  logic [DDW-1:0] wdt;
  logic [DDW-1:0] rdt;
  logic           rdy;

  modport master (output vld, wen, adr, ben, wdt, input rdt, rdy);
  modport slave  (input vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface

// File: rtl/tcb_riscv_test_ctl.sv
// rtl/tcb_riscv_test_ctl.sv - RISC-V compliance test controller: signature, halt, timeout, console
module tcb_riscv_test_ctl #(
  parameter int          DAW = 22,
  parameter int          DDW = 32,
  parameter int unsigned TMO = 0,
  parameter int          DRN = 4,
  parameter logic [31:0] ID  = 32'h5250_0001
)(
  input  logic           clk,
  input  logic           rst,
  tcb_riscv_test_ctl_if.slave tcb,
  output logic [DDW-1:0] sig_begin,
  output logic [DDW-1:0] sig_end,
  output logic [DDW-2:0] halt_code,
  output logic           timeout,
  output logic           done,
  output logic           putc_vld,
  output logic [7:0]     putc_dat
);
  localparam int DBW = DDW/8;
  localparam int ALW = $clog2(DBW);
  localparam logic [7:0] DRN_M1 = 8'(DRN-1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DDW-1:0] sig_begin_q, sig_begin_d;
  logic [DDW-1:0] sig_end_q, sig_end_d;
  logic [DDW-2:0] halt_code_q, halt_code_d;
  logic [DDW-1:0] cycle_q, cycle_d;
  logic [DDW-1:0] tmo_q, tmo_d;
  logic [DDW-1:0] rdt_q, rdt_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  logic           putc_vld_q, putc_vld_d;
  logic [7:0]     putc_dat_q, putc_dat_d;

  logic       wr, rd, halt_req, tmo_hit;
  logic [2:0] idx;
  logic       unused_adr;

  assign tcb.rdy    = 1'b1;
  assign idx        = tcb.adr[ALW+2:ALW];
  assign wr         = tcb.vld & tcb.rdy & tcb.wen;
  assign rd         = tcb.vld & tcb.rdy & ~tcb.wen;
  assign unused_adr = ^{tcb.adr[DAW-1:ALW+3], tcb.adr[ALW-1:0]};

  function automatic logic [DDW-1:0] bmerge(input logic [DDW-1:0] old,
                                            input logic [DDW-1:0] nw,
                                            input logic [DBW-1:0] ben);
    logic [DDW-1:0] r;
    r = old;
    for (int b = 0; b < DBW; b++)
      if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    sig_begin_d = sig_begin_q;
    sig_end_d   = sig_end_q;
    halt_code_d = halt_code_q;
    cycle_d     = cycle_q;
    tmo_d       = tmo_q;
    rdt_d       = rdt_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    putc_vld_d  = 1'b0;
    putc_dat_d  = putc_dat_q;

    if (wr && idx == 3'd0) sig_begin_d = bmerge(sig_begin_q, tcb.wdt, tcb.ben);
    if (wr && idx == 3'd1) sig_end_d   = bmerge(sig_end_q, tcb.wdt, tcb.ben);
    if (wr && idx == 3'd4) tmo_d       = bmerge(tmo_q, tcb.wdt, tcb.ben);
    if (wr && idx == 3'd5 && tcb.ben[0]) begin
      putc_vld_d = 1'b1;
      putc_dat_d = tcb.wdt[7:0];
    end

    if (state_q == ST_RUN && cycle_q != '1) cycle_d = cycle_q + DDW'(1);

    // Timeout compares against the upcoming count so DRAIN starts on the edge CYCLE hits the limit.
    halt_req = wr && idx == 3'd2 && tcb.ben[0] && tcb.wdt[0] && state_q == ST_RUN;
    tmo_hit  = state_q == ST_RUN && tmo_q != '0 && cycle_d == tmo_q;

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d     = ST_DRAIN;
          halt_code_d = tcb.wdt[DDW-1:1];
          cnt_d       = DRN_M1;
        end else if (tmo_hit) begin
          state_d   = ST_DRAIN;
          timeout_d = 1'b1;
          cnt_d     = DRN_M1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 8'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase

    if (rd) begin
      case (idx)
        3'd0:    rdt_d = sig_begin_q;
        3'd1:    rdt_d = sig_end_q;
        3'd2:    rdt_d = {halt_code_q, state_q != ST_RUN};
        3'd3:    rdt_d = cycle_q;
        3'd4:    rdt_d = tmo_q;
        3'd6:    rdt_d = {{(DDW-4){1'b0}}, state_q == ST_DONE, timeout_q, state_q};
        3'd7:    rdt_d = DDW'(ID);
        default: rdt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      sig_begin_q <= '0;
      sig_end_q   <= '0;
      halt_code_q <= '0;
      cycle_q     <= '0;
      tmo_q       <= DDW'(TMO);
      rdt_q       <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      putc_vld_q  <= 1'b0;
      putc_dat_q  <= '0;
    end else begin
      state_q     <= state_d;
      sig_begin_q <= sig_begin_d;
      sig_end_q   <= sig_end_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
      tmo_q       <= tmo_d;
      rdt_q       <= rdt_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      putc_vld_q  <= putc_vld_d;
      putc_dat_q  <= putc_dat_d;
    end
  end

  assign tcb.rdt   = rdt_q;
  assign sig_begin = sig_begin_q;
  assign sig_end   = sig_end_q;
  assign halt_code = halt_code_q;
  assign timeout   = timeout_q;
  assign done      = state_q == ST_DONE;
  assign putc_vld  = putc_vld_q;
  assign putc_dat  = putc_dat_q;
endmodule

// File: tb/tb_tcb_riscv_test_ctl.sv
// tb/tb_tcb_riscv_test_ctl.sv - directed self-checking bench for tcb_riscv_test_ctl
module tb_tcb_riscv_test_ctl;
  localparam int DAW = 22;
  localparam int DDW = 32;
  localparam int DRN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sig_begin, sig_end;
  logic [30:0] halt_code;
  logic        timeout, done, putc_vld;
  logic [7:0]  putc_dat;

  int n_err = 0;
  int n_chk = 0;
  int ncyc;

  tcb_riscv_test_ctl_if #(.DAW(DAW), .DDW(DDW)) tcb ();

  tcb_riscv_test_ctl #(.DAW(DAW), .DDW(DDW), .TMO(0), .DRN(DRN), .ID(32'h5250_0001)) dut (
    .clk       (clk),
    .rst       (rst),
    .tcb       (tcb),
    .sig_begin (sig_begin),
    .sig_end   (sig_end),
    .halt_code (halt_code),
    .timeout   (timeout),
    .done      (done),
    .putc_vld  (putc_vld),
    .putc_dat  (putc_dat)
  );

  always #5 clk = ~clk;

  // Edges since reset release; CYCLE should track this while in RUN.
  always @(posedge clk or negedge rst)
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] b);
    tcb.vld = 1'b1; tcb.wen = 1'b1; tcb.adr = DAW'(idx) << 2; tcb.ben = b; tcb.wdt = d;
    @(negedge clk);
    tcb.vld = 1'b0; tcb.wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] d);
    tcb.vld = 1'b1; tcb.wen = 1'b0; tcb.adr = DAW'(idx) << 2; tcb.ben = 4'hF;
    @(negedge clk);
    tcb.vld = 1'b0;
    d = tcb.rdt;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int e, t_ent, d_ent;
    tcb.vld = 1'b0; tcb.wen = 1'b0; tcb.adr = '0; tcb.ben = '0; tcb.wdt = '0;

    repeat (3) @(negedge clk);
    check("rst_rdt", tcb.rdt, 0);
    check("rst_rdy", tcb.rdy, 1);
    check("rst_sig_begin", sig_begin, 0);
    check("rst_halt_code", halt_code, 0);
    check("rst_done", done, 0);
    check("rst_putc_vld", putc_vld, 0);
    rst = 1'b1;

    rd(3'd7, v); check("id", v, 32'h5250_0001);
    e = ncyc; rd(3'd3, v); check("cycle_run", v, e);
    check("cycle_nonzero", v != 0, 1);
    rd(3'd4, v); check("tmo_lim_rst", v, 0);
    rd(3'd6, v); check("status_rst", v, 0);
    rd(3'd5, v); check("putc_read", v, 0);
    check("done_idle", done, 0);

    wr(3'd0, 32'h1000_0200, 4'hF);
    wr(3'd1, 32'h1000_021C, 4'h3);
    check("sig_begin", sig_begin, 32'h1000_0200);
    rd(3'd1, v); check("sig_end_rd", v, 32'h0000_021C);
    wr(3'd4, 32'h0, 4'hF);
    check("rdt_hold", tcb.rdt, 32'h0000_021C);

    // Halt with code 3; drain of DRN edges counted from the transfer edge.
    wr(3'd2, 32'h7, 4'h1);
    e = ncyc;
    check("halt_code", halt_code, 3);
    check("done_in_drain", done, 0);
    rd(3'd6, v); check("status_drain", v, 1);
    rd(3'd2, v); check("halt_rd_drain", v, 7);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("halt_done_lat", ncyc - e, DRN);
    rd(3'd3, v); check("cycle_frozen", v, e);
    rd(3'd6, v); check("status_done", v, 32'hA);
    wr(3'd2, 32'h5, 4'h1);
    check("halt_code_kept", halt_code, 3);
    check("done_sticky", done, 1);

    // Timeout at 100 on an idle bus.
    do_reset();
    wr(3'd4, 32'd100, 4'hF);
    t_ent = -1; d_ent = -1;
    for (int i = 0; i < 300 && d_ent < 0; i++) begin
      if (timeout && t_ent < 0) t_ent = ncyc;
      if (done) d_ent = ncyc;
      else @(negedge clk);
    end
    check("tmo_entry", t_ent, 100);
    check("tmo_done", d_ent, 100 + DRN);
    check("tmo_flag", timeout, 1);
    rd(3'd3, v); check("tmo_cycle", v, 100);
    rd(3'd6, v); check("tmo_status", v, 32'hE);

    // Halt colliding with the timeout edge: halt wins.
    do_reset();
    wr(3'd4, 32'd50, 4'hF);
    for (int i = 0; i < 100 && ncyc < 49; i++) @(negedge clk);
    wr(3'd2, (32'h2A << 1) | 32'h1, 4'h1);
    e = ncyc;
    check("coll_timeout", timeout, 0);
    check("coll_halt_code", halt_code, 32'h2A);
    rd(3'd3, v); check("coll_cycle", v, 50);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("coll_done_lat", ncyc - e, DRN);
    check("coll_timeout_end", timeout, 0);

    // Console back-to-back, then reset in the middle of a drain.
    do_reset();
    wr(3'd0, 32'hDEAD_BEEF, 4'hF);
    rd(3'd7, v);
    tcb.vld = 1'b1; tcb.wen = 1'b1; tcb.adr = DAW'(5) << 2; tcb.ben = 4'h1; tcb.wdt = 32'h4F;
    @(negedge clk);
    check("putc0_vld", putc_vld, 1);
    check("putc0_dat", putc_dat, 8'h4F);
    tcb.wdt = 32'h4B;
    @(negedge clk);
    tcb.vld = 1'b0; tcb.wen = 1'b0;
    check("putc1_vld", putc_vld, 1);
    check("putc1_dat", putc_dat, 8'h4B);
    @(negedge clk);
    check("putc_end", putc_vld, 0);
    wr(3'd2, 32'h11, 4'h1);
    check("drain_code", halt_code, 8);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_rdt", tcb.rdt, 0);
    check("arst_sig_begin", sig_begin, 0);
    check("arst_halt_code", halt_code, 0);
    check("arst_putc_dat", putc_dat, 0);
    check("arst_flags", {done, timeout, putc_vld, tcb.rdy}, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    repeat (DRN + 2) @(negedge clk);
    check("arst_no_done", done, 0);
    rd(3'd6, v); check("arst_status", v, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
